// File: rtl/fsm_ctrl_pkg.sv
// Shared encodings for the run/step controller: requester commands, controller
// states and the round-robin grant marker.
package fsm_ctrl_pkg;

  localparam logic [1:0] CMD_RUN     = 2'b00;
  localparam logic [1:0] CMD_HALT    = 2'b01;
  localparam logic [1:0] CMD_STEP    = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    STEP    = 2'b10,
    RESTART = 2'b11
  } ctrl_state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/pin_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a stability counter; the
// level flips only after DEB_CYCLES consecutive samples disagree with it.
module pin_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any sample matching the current level restarts the stability run.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_step_ctrl.sv
// Run/step controller driving the sequencer's restart/pause from two arbitrated
// requesters and two debounced buttons. FSM_STEP_CTRL_CYCLE_CNT_EN adds cycle_count.
module fsm_step_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart_from_pin,
  input  logic              pause_from_pin,
  input  logic              a_valid,
  input  logic [1:0]        a_cmd,
  input  logic [STEP_W-1:0] a_arg,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [1:0]        b_cmd,
  input  logic [STEP_W-1:0] b_arg,
  output logic              b_ready,
  input  logic              terminal,
  output logic              restart,
  output logic              pause,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left
`ifdef FSM_STEP_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  ctrl_state_t       state;
  grant_t            last_grant;
  logic              restart_db, restart_db_q, pause_db;
  logic              pin_restart_edge;
  logic              grant_a, grant_b, accept_open;
  logic              acc_a, acc_b, acc;
  logic [1:0]        cmd;
  logic [STEP_W-1:0] arg;

  pin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_restart_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (restart_from_pin),
    .level (restart_db)
  );

  pin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (pause_from_pin),
    .level (pause_db)
  );

  assign pin_restart_edge = restart_db && !restart_db_q;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    grant_a = a_valid && (!b_valid || last_grant == GNT_B);
    grant_b = b_valid && (!a_valid || last_grant == GNT_A);
  end

  assign accept_open = (state == IDLE || state == RUN) && !pin_restart_edge;
  assign a_ready     = accept_open && grant_a;
  assign b_ready     = accept_open && grant_b;
  assign acc_a       = a_valid && a_ready;
  assign acc_b       = b_valid && b_ready;
  assign acc         = acc_a || acc_b;
  assign cmd         = acc_a ? a_cmd : b_cmd;
  assign arg         = acc_a ? a_arg : b_arg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GNT_B;
      restart_db_q <= 1'b0;
      restart      <= 1'b0;
      pause        <= 1'b1;
      busy         <= 1'b0;
      steps_left   <= '0;
    end else begin
      restart_db_q <= restart_db;
      restart      <= 1'b0;
      if (pin_restart_edge) begin
        state      <= RESTART;
        restart    <= 1'b1;
        pause      <= 1'b1;
        busy       <= 1'b1;
        steps_left <= '0;
      end else begin
        case (state)
          IDLE, RUN: begin
            if (acc) begin
              last_grant <= acc_a ? GNT_A : GNT_B;
              case (cmd)
                CMD_RUN: begin
                  state <= RUN;
                  pause <= pause_db;
                end
                CMD_HALT: begin
                  state <= IDLE;
                  pause <= 1'b1;
                end
                CMD_STEP: begin
                  if (arg != '0) begin
                    state      <= STEP;
                    steps_left <= arg;
                    pause      <= pause_db;
                    busy       <= 1'b1;
                  end else begin
                    pause <= (state == IDLE) || pause_db;
                  end
                end
                default: begin
                  state   <= RESTART;
                  restart <= 1'b1;
                  pause   <= 1'b1;
                  busy    <= 1'b1;
                end
              endcase
            end else begin
              pause <= (state == IDLE) || pause_db;
            end
          end
          STEP: begin
            // Count only cycles the sequencer actually ran; pin pause freezes it.
            if (!pause) begin
              steps_left <= steps_left - 1'b1;
              if (steps_left == STEP_W'(1)) begin
                state <= IDLE;
                pause <= 1'b1;
                busy  <= 1'b0;
              end else begin
                pause <= pause_db;
              end
            end else begin
              pause <= pause_db;
            end
          end
          default: begin
            state <= IDLE;
            pause <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FSM_STEP_CTRL_CYCLE_CNT_EN
  logic enter_restart;
  assign enter_restart = pin_restart_edge || (acc && cmd == CMD_RESTART);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cycle_count <= '0;
    else if (enter_restart) cycle_count <= '0;
    else if (terminal)      cycle_count <= cycle_count + 16'd1;
  end
`else
  logic unused_terminal;
  assign unused_terminal = terminal;
`endif

endmodule

// File: doc/fsm_step_ctrl.md
# fsm_step_ctrl

Run/step controller for the three-state odd/even sequencer. It arbitrates commands from two requesters (A: host/debug port, B: test sequencer) and debounces the two board buttons. It drives the sequencer's `restart` and `pause` inputs so the sequencer can be held, free-run, single-stepped for N cycles, or restarted. It sits between the pin/VIO sources and the sequencer and replaces the current direct OR of those sources.

## Interface
- `STEP_W`, 8: width of the step-count argument and `steps_left`.
- `DEB_CYCLES`, 16: number of consecutive stable synchronized samples a button needs before its debounced value changes.

- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high.
- `restart_from_pin`  in  1  raw asynchronous restart button.
- `pause_from_pin`  in  1  raw asynchronous pause button.
- `a_valid`, `b_valid`  in  1  requester command valid.
- `a_cmd`, `b_cmd`  in  2  command: 00 RUN, 01 HALT, 10 STEP, 11 RESTART.
- `a_arg`, `b_arg`  in  STEP_W  step count; only meaningful for STEP.
- `a_ready`, `b_ready`  out  1  command accepted when valid && ready.
- `terminal`  in  1  terminal pulse from the sequencer.
- `restart`  out  1  to the sequencer.
- `pause`  out  1  to the sequencer.
- `busy`  out  1  high in STEP or RESTART.
- `steps_left`  out  STEP_W  remaining step cycles.
- `cycle_count`  out  16  completed sequences; present only with the macro.

## Operation
- Controller states:
  - IDLE: pause=1.
  - RUN: pause=0.
  - STEP: pause=0 while `steps_left` > 0.
  - RESTART: restart=1, pause=1, for exactly one cycle.
- Accept window: commands are accepted only in IDLE and RUN.
  - `x_ready` = (state ∈ {IDLE, RUN}) && !pin_restart_edge && (arbitration grant to x).
- Arbitration: round-robin between A and B, applied only when both are valid.
  - The last-grant register updates on each accept.
  - It resets to B, so A wins the first tie.
  - A lone valid requester is granted immediately.
- Transitions on accept:
  - RUN → RUN.
  - HALT → IDLE.
  - STEP with arg>0 → STEP, with `steps_left` loaded with arg.
  - STEP with arg=0 → no-op; state unchanged.
  - RESTART → RESTART.
- STEP behaviour:
  - `steps_left` decrements on every cycle in which pause=0.
  - When it reaches 0, the next state is IDLE.
  - STEP is not interruptible by requesters.
- RESTART always returns to IDLE after its single cycle.
- Pin restart:
  - A rising edge of the debounced restart enters RESTART from any state.
  - This aborts STEP and clears `steps_left`.
  - It takes priority over any requester in the same cycle; that requester sees ready=0.
- Pin pause:
  - While the debounced level is 1, pause is forced to 1 in every state.
  - In STEP, `steps_left` freezes while pin pause is held.
  - Requests are still accepted while pin pause is held.
- Debounce: 2-flop synchronizer, then a counter.
  - The output toggles after DEB_CYCLES consecutive samples that differ from the current output.
  - Any glitch shorter than that resets the counter.
- Reset values: state IDLE, restart=0, pause=1, busy=0, steps_left=0, debounced values 0, cycle_count=0.
  - `ready` is combinational; after reset a valid requester is ready.

## Timing
- `restart`, `pause`, `busy`, `steps_left` are registered.
- An accept on edge N takes effect in the outputs from edge N+1.
- STEP with arg=k gives pause=0 for exactly k clk cycles (pin pause not held), then pause=1.
- Button-to-effect latency: 2 sync cycles + DEB_CYCLES + 1 cycle.
- `rst` asserted mid-operation immediately forces the reset values, with no clock edge required.

## Configuration
- `FSM_STEP_CTRL_CYCLE_CNT_EN`:
  - Defined: `cycle_count` increments (wrapping at 2^16) on each cycle where `terminal`=1, and clears when the controller enters RESTART.
  - Undefined: no `cycle_count` port and no counter logic.

## Structure
- Shared package `fsm_ctrl_pkg` holds:
  - command encodings CMD_RUN/HALT/STEP/RESTART;
  - the controller state enum (IDLE, RUN, STEP, RESTART).
- One sub-module, `pin_debounce` (parameter DEB_CYCLES), instantiated twice: once per button.

## Test plan
- Reset, then A issues STEP arg=3 → pause=0 for exactly 3 cycles starting at N+1; busy=1 during that time; then IDLE with pause=1 and steps_left=0.
- A and B both valid, RUN and HALT, in IDLE → A granted first (state RUN); on the next cycle B granted (state IDLE).
- In STEP with steps_left=5, press restart pin for DEB_CYCLES+4 cycles → exactly one restart=1 cycle, steps_left=0, then IDLE; a requester valid on the edge cycle sees ready=0.
- RUN, hold pause pin → pause=1 after 2+DEB_CYCLES+1 cycles; a 10-cycle glitch (DEB_CYCLES=16) → pause stays 0.
- STEP arg=0 in IDLE → accepted; state stays IDLE; pause stays 1.
- With `FSM_STEP_CTRL_CYCLE_CNT_EN`, RUN for 30 cycles with terminal pulsing every 3 cycles → cycle_count=10; a RESTART command → cycle_count=0.
